// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetches to a variable-latency
// memory, buffers in-order responses and hands them to decode; redirects drop stale work.
module fetch_queue #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic [XLEN-1:0]        i_flush_addr,
    output logic                   o_ireq,
    output logic [XLEN-1:0]        o_iaddr,
    input  logic                   i_igrant,
    input  logic                   i_irvalid,
    input  logic [XLEN-1:0]        i_irdata,
    output logic                   o_valid,
    output logic [XLEN-1:0]        o_inst,
    output logic [XLEN-1:0]        o_pc,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = PW + 1;

    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_fill;
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_discard;
    logic [XLEN-1:0]  r_fpc;
    logic             r_active;
    logic [DEPTH-1:0] r_filled;
    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [XLEN-1:0]  r_inst [DEPTH];

    logic [PW-1:0]    w_occ;
    logic [PW-1:0]    w_pend;
    logic [SW-1:0]    w_budget;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_fill_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_ireq;
    logic             w_valid;
    logic             w_grant;
    logic             w_consume;
    logic             w_drop;
    logic             w_fill;

    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_fill_nxt;
    logic [PW-1:0]    w_rd_nxt;
    logic [PW-1:0]    w_discard_nxt;
    logic [XLEN-1:0]  w_fpc_nxt;
    logic [DEPTH-1:0] w_filled_nxt;

    // Occupancy counts allocated entries; w_pend is what memory still owes the buffer.
    assign w_occ      = r_wr - r_rd;
    assign w_pend     = r_wr - r_fill;
    assign w_wr_idx   = r_wr[AW-1:0];
    assign w_fill_idx = r_fill[AW-1:0];
    assign w_rd_idx   = r_rd[AW-1:0];

    // Stale responses still in flight count against the budget so memory never owes more than DEPTH.
    assign w_budget  = SW'(w_occ) + SW'(r_discard);
    assign w_ireq    = r_active && !i_flush && (w_budget < SW'(DEPTH));
    assign w_valid   = !i_flush && (w_occ != '0) && r_filled[w_rd_idx];
    assign w_grant   = w_ireq && i_igrant;
    assign w_consume = w_valid && i_ready;
    assign w_drop    = i_irvalid && (r_discard != '0);
    assign w_fill    = i_irvalid && (r_discard == '0) && (r_fill != r_wr);

    // Next-state: a flush overrides every other event in its cycle.
    always_comb begin
        w_wr_nxt      = r_wr;
        w_fill_nxt    = r_fill;
        w_rd_nxt      = r_rd;
        w_discard_nxt = r_discard;
        w_fpc_nxt     = r_fpc;
        w_filled_nxt  = r_filled;

        if (i_flush) begin
            w_wr_nxt      = '0;
            w_fill_nxt    = '0;
            w_rd_nxt      = '0;
            w_filled_nxt  = '0;
            w_fpc_nxt     = i_flush_addr;
            // Everything still owed by memory becomes stale, less the response landing now.
            w_discard_nxt = r_discard + w_pend - PW'(w_drop || w_fill);
        end else begin
            if (w_grant) begin
                w_wr_nxt               = r_wr + PW'(1);
                w_fpc_nxt              = r_fpc + XLEN'(4);
                w_filled_nxt[w_wr_idx] = 1'b0;
            end
            if (w_drop) begin
                w_discard_nxt = r_discard - PW'(1);
            end
            if (w_fill) begin
                w_fill_nxt               = r_fill + PW'(1);
                w_filled_nxt[w_fill_idx] = 1'b1;
            end
            if (w_consume) begin
                w_rd_nxt               = r_rd + PW'(1);
                w_filled_nxt[w_rd_idx] = 1'b0;
            end
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr      <= '0;
            r_fill    <= '0;
            r_rd      <= '0;
            r_discard <= '0;
            r_fpc     <= RESET_VECTOR;
            r_filled  <= '0;
            r_active  <= 1'b0;
        end else begin
            r_wr      <= w_wr_nxt;
            r_fill    <= w_fill_nxt;
            r_rd      <= w_rd_nxt;
            r_discard <= w_discard_nxt;
            r_fpc     <= w_fpc_nxt;
            r_filled  <= w_filled_nxt;
            r_active  <= 1'b1;
        end
    end

    // Payload storage; validity is tracked by r_filled, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_pc[w_wr_idx] <= r_fpc;
        end
        if (w_fill && !i_flush) begin
            r_inst[w_fill_idx] <= i_irdata;
        end
    end

    assign o_ireq  = w_ireq;
    assign o_iaddr = r_fpc;
    assign o_valid = w_valid;
    assign o_inst  = r_inst[w_rd_idx];
    assign o_pc    = r_pc[w_rd_idx];
    assign o_count = w_occ;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural in-order memory plus a scoreboard of
// expected {pc, inst} pairs pushed at grant and popped at each decode handshake.
module tb_fetch_queue;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic [31:0] i_flush_addr;
    logic        o_ireq;
    logic [31:0] o_iaddr;
    logic        i_igrant;
    logic        i_irvalid;
    logic [31:0] i_irdata;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready;
    logic [2:0]  o_count;

    exp_t  sb[$];
    pend_t pend[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_grants = 0;
    int          n_cons = 0;
    int          max_inflight = 0;
    logic [31:0] exp_fpc = RV;
    logic [31:0] last_grant_addr = '0;
    logic [31:0] last_cons_pc = '0;

    bit          g_grant_en = 0;
    bit          g_resp_en = 0;
    bit          g_ready = 0;
    bit          g_flush = 0;
    int          g_lat = 1;
    logic [31:0] g_flush_addr = '0;

    fetch_queue #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_flush(i_flush),
        .i_flush_addr(i_flush_addr),
        .o_ireq(o_ireq),
        .o_iaddr(o_iaddr),
        .i_igrant(i_igrant),
        .i_irvalid(i_irvalid),
        .i_irdata(i_irdata),
        .o_valid(o_valid),
        .o_inst(o_inst),
        .o_pc(o_pc),
        .i_ready(i_ready),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive at negedge, observe 1ns later, update memory and scoreboard.
    task automatic tick();
        exp_t e;
        bit   resp_now;
        @(negedge clk);
        resp_now = g_resp_en && (pend.size() > 0) && (pend[0].due <= cyc);
        i_irvalid    = resp_now;
        i_irdata     = resp_now ? pend[0].data : 32'hDEAD_BEEF;
        i_igrant     = g_grant_en;
        i_ready      = g_ready;
        i_flush      = g_flush;
        i_flush_addr = g_flush_addr;
        #1;
        if (g_flush) begin
            n_checks++;
            if (o_ireq !== 1'b0) $display("FAIL flush_ireq: got %b expected 0", o_ireq);
            else n_pass++;
            n_checks++;
            if (o_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", o_valid);
            else n_pass++;
        end
        if (o_ireq === 1'b1 && i_igrant) begin
            n_checks++;
            if (o_iaddr !== exp_fpc) $display("FAIL iaddr: got %h expected %h", o_iaddr, exp_fpc);
            else n_pass++;
            pend.push_back('{data: exp_fpc ^ MASK, due: cyc + g_lat});
            sb.push_back('{pc: exp_fpc, inst: exp_fpc ^ MASK});
            last_grant_addr = o_iaddr;
            exp_fpc = exp_fpc + 32'd4;
            n_grants++;
        end
        if (o_valid === 1'b1 && i_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_valid: got pc %h, nothing expected", o_pc);
            end else begin
                e = sb.pop_front();
                if (o_pc !== e.pc || o_inst !== e.inst)
                    $display("FAIL head: got pc %h inst %h expected pc %h inst %h",
                             o_pc, o_inst, e.pc, e.inst);
                else n_pass++;
            end
            last_cons_pc = o_pc;
            n_cons++;
        end
        if (resp_now) void'(pend.pop_front());
        if (pend.size() > max_inflight) max_inflight = pend.size();
        if (g_flush) begin
            sb.delete();
            exp_fpc = g_flush_addr;
        end
        cyc++;
    endtask

    task automatic do_reset();
        g_grant_en = 0; g_resp_en = 1; g_flush = 0; g_ready = 1;
        for (int k = 0; k < 40 && pend.size() > 0; k++) tick();
        if (pend.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", pend.size());
        end
        g_resp_en = 0;
        @(negedge clk);
        rst = 1'b0; i_irvalid = 1'b0; i_flush = 1'b0; i_igrant = 1'b0;
        sb.delete();
        exp_fpc = RV;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Four grants, entries 0x0/0x4 filled, 0x0 consumed: head 0x4, 0x8/0xC in flight.
    task automatic setup_head4();
        int g0;
        do_reset();
        g_ready = 0; g_lat = 1; g_resp_en = 0; g_grant_en = 1;
        g0 = n_grants;
        repeat (6) tick();
        n_checks++;
        if (n_grants - g0 != 4) $display("FAIL setup_grants: got %0d expected 4", n_grants - g0);
        else n_pass++;
        g_grant_en = 0;
        g_resp_en = 1; repeat (2) tick(); g_resp_en = 0;
        g_ready = 1; tick(); g_ready = 0;
        tick();
        n_checks++;
        if (o_count !== 3'd3 || o_valid !== 1'b1 || o_pc !== 32'h4)
            $display("FAIL setup_state: got count %0d valid %b pc %h expected 3 1 00000004",
                     o_count, o_valid, o_pc);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0)
            $display("FAIL reset_valid_count: got %b %0d expected 0 0", o_valid, o_count);
        else n_pass++;
        n_checks++;
        if (o_ireq !== 1'b0 || o_iaddr !== RV)
            $display("FAIL reset_ireq_addr: got %b %h expected 0 %h", o_ireq, o_iaddr, RV);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (o_ireq !== 1'b1 || o_iaddr !== RV)
            $display("FAIL reset_release: got ireq %b addr %h expected 1 %h", o_ireq, o_iaddr, RV);
        else n_pass++;
    endtask

    task automatic test_stream();
        int c0;
        do_reset();
        g_lat = 1; g_grant_en = 1; g_resp_en = 1; g_ready = 1;
        c0 = n_cons;
        tick(); tick();
        n_checks++;
        if (n_cons - c0 != 0) $display("FAIL stream_early: got %0d consumed expected 0", n_cons - c0);
        else n_pass++;
        tick();
        n_checks++;
        if (n_cons - c0 != 1 || last_cons_pc !== RV)
            $display("FAIL stream_first: got %0d pc %h expected 1 %h", n_cons - c0, last_cons_pc, RV);
        else n_pass++;
        repeat (3) tick();
        c0 = n_cons;
        repeat (10) tick();
        n_checks++;
        if (n_cons - c0 != 10) $display("FAIL stream_rate: got %0d expected 10", n_cons - c0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int g0;
        do_reset();
        g_ready = 0; g_lat = 1; g_grant_en = 1; g_resp_en = 1;
        g0 = n_grants;
        repeat (8) tick();
        n_checks++;
        if (n_grants - g0 != 4) $display("FAIL bp_grants: got %0d expected 4", n_grants - g0);
        else n_pass++;
        n_checks++;
        if (o_ireq !== 1'b0 || o_count !== 3'd4)
            $display("FAIL bp_full: got ireq %b count %0d expected 0 4", o_ireq, o_count);
        else n_pass++;
        n_checks++;
        if (o_valid !== 1'b1 || o_pc !== RV || o_inst !== (RV ^ MASK))
            $display("FAIL bp_head: got %b %h %h expected 1 %h %h", o_valid, o_pc, o_inst, RV, RV ^ MASK);
        else n_pass++;
        g_ready = 1;
        g0 = n_grants;
        for (int k = 0; k < 6 && n_grants == g0; k++) tick();
        n_checks++;
        if (n_grants == g0 || last_grant_addr !== 32'h10)
            $display("FAIL bp_resume: got addr %h expected 00000010", last_grant_addr);
        else n_pass++;
        repeat (8) tick();
    endtask

    task automatic test_latency();
        int first;
        int c10;
        do_reset();
        max_inflight = 0;
        g_lat = 3; g_grant_en = 1; g_resp_en = 1; g_ready = 1;
        first = -1;
        c10 = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (first < 0 && o_valid === 1'b1) first = k;
            if (k == 9) c10 = n_cons;
        end
        n_checks++;
        if (first != 4) $display("FAIL lat_first_valid: got cycle %0d expected 4", first);
        else n_pass++;
        n_checks++;
        if (max_inflight != 3) $display("FAIL lat_inflight: got %0d expected 3", max_inflight);
        else n_pass++;
        n_checks++;
        if (n_cons - c10 != 16) $display("FAIL lat_throughput: got %0d expected 16", n_cons - c10);
        else n_pass++;
    endtask

    task automatic test_flush_inflight();
        int c0;
        setup_head4();
        g_flush = 1; g_flush_addr = 32'h100; g_grant_en = 1; g_resp_en = 0;
        tick();
        g_flush = 0; g_ready = 1; g_resp_en = 1;
        c0 = n_cons;
        tick();
        n_checks++;
        if (o_count !== 3'd0 || o_valid !== 1'b0)
            $display("FAIL fi_after: got count %0d valid %b expected 0 0", o_count, o_valid);
        else n_pass++;
        for (int k = 0; k < 20 && n_cons == c0; k++) tick();
        n_checks++;
        if (n_cons == c0 || last_cons_pc !== 32'h100)
            $display("FAIL fi_target: got pc %h expected 00000100", last_cons_pc);
        else n_pass++;
        repeat (6) tick();
    endtask

    task automatic test_flush_coincident();
        int c0;
        setup_head4();
        g_flush = 1; g_flush_addr = 32'h200; g_grant_en = 1; g_resp_en = 1; g_ready = 1;
        c0 = n_cons;
        tick();
        g_flush = 0;
        n_checks++;
        if (n_cons != c0) $display("FAIL fc_consumed: got %0d expected 0", n_cons - c0);
        else n_pass++;
        tick();
        n_checks++;
        if (o_count !== 3'd0) $display("FAIL fc_count: got %0d expected 0", o_count);
        else n_pass++;
        for (int k = 0; k < 20 && n_cons == c0; k++) tick();
        n_checks++;
        if (n_cons == c0 || last_cons_pc !== 32'h200)
            $display("FAIL fc_target: got pc %h expected 00000200", last_cons_pc);
        else n_pass++;
        repeat (6) tick();
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        g_lat = 2; g_grant_en = 1; g_resp_en = 1; g_ready = 1;
        repeat (6) tick();
        g_flush = 1; g_flush_addr = 32'h300; tick();
        g_flush_addr = 32'h400; tick();
        g_flush = 0;
        c0 = n_cons;
        for (int k = 0; k < 20 && n_cons == c0; k++) tick();
        n_checks++;
        if (n_cons == c0 || last_cons_pc !== 32'h400)
            $display("FAIL b2b_target: got pc %h expected 00000400", last_cons_pc);
        else n_pass++;
        repeat (6) tick();
    endtask

    task automatic test_async_reset();
        int c0;
        do_reset();
        g_ready = 0; g_lat = 1; g_resp_en = 0; g_grant_en = 1;
        repeat (3) tick();
        g_grant_en = 0;
        g_resp_en = 1; tick(); g_resp_en = 0;
        tick();
        n_checks++;
        if (o_count !== 3'd3 || o_valid !== 1'b1)
            $display("FAIL ar_pre: got count %0d valid %b expected 3 1", o_count, o_valid);
        else n_pass++;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0)
            $display("FAIL ar_immediate: got valid %b count %0d expected 0 0", o_valid, o_count);
        else n_pass++;
        n_checks++;
        if (o_ireq !== 1'b0 || o_iaddr !== RV)
            $display("FAIL ar_ireq: got %b %h expected 0 %h", o_ireq, o_iaddr, RV);
        else n_pass++;
        sb.delete();
        exp_fpc = RV;
        @(negedge clk);
        rst = 1'b1;
        g_resp_en = 1; g_grant_en = 0;
        tick();
        n_checks++;
        if (o_ireq !== 1'b1 || o_iaddr !== RV)
            $display("FAIL ar_release: got %b %h expected 1 %h", o_ireq, o_iaddr, RV);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (o_count !== 3'd0 || o_valid !== 1'b0)
            $display("FAIL ar_late_resp: got count %0d valid %b expected 0 0", o_count, o_valid);
        else n_pass++;
        g_grant_en = 1; g_ready = 1;
        c0 = n_cons;
        repeat (10) tick();
        n_checks++;
        if (n_cons - c0 != 8) $display("FAIL ar_restream: got %0d expected 8", n_cons - c0);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        i_flush = 1'b0; i_flush_addr = '0; i_igrant = 1'b0;
        i_irvalid = 1'b0; i_irdata = '0; i_ready = 1'b0;
        #1 rst = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_flush_inflight();
        test_flush_coincident();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
